// File: rtl/aes_round_key_store_pkg.sv
// Shared constants, state encoding and GF(2^8) helper for the AES-128 round-key store.
package aes_round_key_store_pkg;

  localparam int KEY_SIZE     = 128;
  localparam int NO_OF_ROUNDS = 10;
  localparam logic R_ACTIV    = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_e;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round_key_store_if.sv
// Key-load and round-key read bus between the cipher controller and the key store.
interface aes_round_key_store_if;
  import aes_round_key_store_pkg::*;

  logic                start;
  logic [KEY_SIZE-1:0] key;
  logic                busy;
  logic                key_valid;
  logic                rd_en;
  logic [3:0]          rd_idx;
  logic                rd_reverse;
  logic [KEY_SIZE-1:0] rd_key;
  logic                rd_ack;

  modport master (
    output start, key, rd_en, rd_idx, rd_reverse,
    input  busy, key_valid, rd_key, rd_ack
  );

  modport slave (
    input  start, key, rd_en, rd_idx, rd_reverse,
    output busy, key_valid, rd_key, rd_ack
  );

endinterface

// File: rtl/aes_sub_word.sv
// 32-bit forward AES SubWord: four independent byte S-box lookups.
module aes_sub_word (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  // Row-major S-box; entry 0 sits in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  always_comb begin
    dout = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};
  end

endmodule

// File: rtl/aes_round_key_store.sv
// Iterative AES-128 key expander that buffers all round keys and serves them
// by index in encrypt or decrypt order with one cycle of read latency.
module aes_round_key_store
  import aes_round_key_store_pkg::*;
(
  input logic              clk,
  input logic              reset,
  aes_round_key_store_if.slave bus
);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [7:0]          rcon_q, rcon_d;
  logic                busy_q, busy_d;
  logic                key_valid_q, key_valid_d;
  logic [KEY_SIZE-1:0] rd_key_q, rd_key_d;
  logic                rd_ack_q, rd_ack_d;

  logic [KEY_SIZE-1:0] w_q, w_d;
  logic [KEY_SIZE-1:0] key_buf_q [NO_OF_ROUNDS+1];
  logic                buf_we;
  logic [3:0]          buf_widx;
  logic [KEY_SIZE-1:0] buf_wdata;

  logic [31:0]         rot_w3, sub_w3, t_word;
  logic [31:0]         n0, n1, n2, n3;
  logic [KEY_SIZE-1:0] next_rk;
  logic [3:0]          eff_idx;

  // One key-schedule round from the working register.
  assign rot_w3 = {w_q[23:0], w_q[31:24]};

  aes_sub_word u_sub_word (
    .din  (rot_w3),
    .dout (sub_w3)
  );

  assign t_word  = sub_w3 ^ {rcon_q, 24'h0};
  assign n0      = w_q[127:96] ^ t_word;
  assign n1      = w_q[95:64]  ^ n0;
  assign n2      = w_q[63:32]  ^ n1;
  assign n3      = w_q[31:0]   ^ n2;
  assign next_rk = {n0, n1, n2, n3};

  // In decrypt order the mirror of an in-range index is also in range.
  assign eff_idx = bus.rd_reverse ? (4'(NO_OF_ROUNDS) - bus.rd_idx) : bus.rd_idx;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rcon_d      = rcon_q;
    busy_d      = busy_q;
    key_valid_d = key_valid_q;
    w_d         = w_q;
    buf_we      = 1'b0;
    buf_widx    = cnt_q;
    buf_wdata   = next_rk;

    case (state_q)
      IDLE, READY: begin
        if (bus.start) begin
          buf_we      = 1'b1;
          buf_widx    = 4'd0;
          buf_wdata   = bus.key;
          w_d         = bus.key;
          cnt_d       = 4'd1;
          rcon_d      = 8'h01;
          busy_d      = 1'b1;
          key_valid_d = 1'b0;
          state_d     = EXPAND;
        end
      end
      EXPAND: begin
        buf_we = 1'b1;
        w_d    = next_rk;
        cnt_d  = cnt_q + 4'd1;
        rcon_d = xtime(rcon_q);
        if (cnt_q == 4'(NO_OF_ROUNDS)) begin
          cnt_d       = 4'd0;
          busy_d      = 1'b0;
          key_valid_d = 1'b1;
          state_d     = READY;
        end
      end
      default: state_d = IDLE;
    endcase

    rd_ack_d = 1'b0;
    rd_key_d = rd_key_q;
    if (bus.rd_en && key_valid_q) begin
      rd_ack_d = 1'b1;
      rd_key_d = (bus.rd_idx <= 4'(NO_OF_ROUNDS)) ? key_buf_q[eff_idx] : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset == R_ACTIV) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rcon_q      <= '0;
      busy_q      <= 1'b0;
      key_valid_q <= 1'b0;
      rd_key_q    <= '0;
      rd_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rcon_q      <= rcon_d;
      busy_q      <= busy_d;
      key_valid_q <= key_valid_d;
      rd_key_q    <= rd_key_d;
      rd_ack_q    <= rd_ack_d;
    end
  end

  // Key storage is pure data and carries no reset.
  always_ff @(posedge clk) begin
    w_q <= w_d;
    if (buf_we) key_buf_q[buf_widx] <= buf_wdata;
  end

  assign bus.busy      = busy_q;
  assign bus.key_valid = key_valid_q;
  assign bus.rd_key    = rd_key_q;
  assign bus.rd_ack    = rd_ack_q;

endmodule

// File: tb/tb_aes_round_key_store.sv
// Directed bench for aes_round_key_store with a read scoreboard keyed on expected ack cycle.
module tb_aes_round_key_store;
  import aes_round_key_store_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_round_key_store_if bus ();

  aes_round_key_store dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int           cyc;
    logic [127:0] key;
    string        tag;
  } exp_t;

  exp_t         sbq[$];
  int           n_assert = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  logic [127:0] rk [11];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] Z_RK1    = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_RK10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each accepted read must ack exactly on its recorded cycle.
  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      chk({sbq[0].tag, " ack"}, {127'b0, bus.rd_ack}, 128'd1);
      if (bus.rd_ack === 1'b1) chk(sbq[0].tag, bus.rd_key, sbq[0].key);
      void'(sbq.pop_front());
    end else if (bus.rd_ack !== 1'b0) begin
      chk("unexpected rd_ack", {127'b0, bus.rd_ack}, 128'd0);
    end
  end

  task automatic rd(input logic [3:0] idx, input logic rev, input logic [127:0] exp, input string tag);
    @(negedge clk);
    bus.rd_en      = 1'b1;
    bus.rd_idx     = idx;
    bus.rd_reverse = rev;
    sbq.push_back('{cyc + 1, exp, tag});
  endtask

  task automatic idle();
    @(negedge clk);
    bus.rd_en = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic run_exp(input logic [127:0] k, input bit glitch, input bit rd_old,
                         input logic [127:0] old_exp);
    @(negedge clk);
    bus.start = 1'b1;
    bus.key   = k;
    bus.rd_en = rd_old;
    if (rd_old) begin
      bus.rd_idx     = 4'd10;
      bus.rd_reverse = 1'b0;
      sbq.push_back('{cyc + 1, old_exp, "rd with start"});
    end
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      bus.rd_en = 1'b0;
      bus.start = glitch && (i == 3 || i == 6);
      bus.key   = bus.start ? ~k : k;
      chk($sformatf("busy c%0d", i), {127'b0, bus.busy}, {127'b0, (i <= 10)});
      chk($sformatf("key_valid c%0d", i), {127'b0, bus.key_valid}, {127'b0, (i == 11)});
    end
    bus.start = 1'b0;
    bus.key   = k;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rk[0]  = FIPS_KEY;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.key        = '0;
    bus.rd_en      = 1'b0;
    bus.rd_idx     = '0;
    bus.rd_reverse = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy",      {127'b0, bus.busy},      128'd0);
    chk("reset key_valid", {127'b0, bus.key_valid}, 128'd0);
    chk("reset rd_key",    bus.rd_key,              128'd0);
    chk("reset rd_ack",    {127'b0, bus.rd_ack},    128'd0);
    @(negedge clk);
    reset = 1'b0;

    // FIPS-197 key, all entries forward back to back, then decrypt order.
    run_exp(FIPS_KEY, 1'b0, 1'b0, '0);
    for (int i = 0; i <= 10; i++) rd(4'(i), 1'b0, rk[i], $sformatf("fwd idx%0d", i));
    rd(4'd0,  1'b1, rk[10], "rev idx0");
    rd(4'd10, 1'b1, rk[0],  "rev idx10");
    rd(4'd3,  1'b1, rk[7],  "rev idx3");
    idle();

    // All-zero key including an out-of-range index.
    run_exp('0, 1'b0, 1'b0, '0);
    rd(4'd1,  1'b0, Z_RK1,  "zero idx1");
    rd(4'd10, 1'b0, Z_RK10, "zero idx10");
    rd(4'd15, 1'b0, '0,     "zero idx15");
    rd(4'd0,  1'b0, '0,     "zero idx0");
    idle();

    // Starts during expansion must not disturb the running schedule.
    run_exp(FIPS_KEY, 1'b1, 1'b0, '0);
    rd(4'd10, 1'b0, rk[10], "glitch idx10");
    rd(4'd5,  1'b0, rk[5],  "glitch idx5");
    idle();

    // New start together with a read: read sees the old contents.
    run_exp('0, 1'b0, 1'b1, rk[10]);
    rd(4'd1,  1'b0, Z_RK1,  "restart idx1");
    rd(4'd10, 1'b0, Z_RK10, "restart idx10");
    idle();

    // Asynchronous reset in the middle of an expansion.
    @(negedge clk);
    bus.start = 1'b1;
    bus.key   = FIPS_KEY;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async busy",      {127'b0, bus.busy},      128'd0);
    chk("async key_valid", {127'b0, bus.key_valid}, 128'd0);
    chk("async rd_key",    bus.rd_key,              128'd0);
    @(negedge clk);
    reset      = 1'b0;
    bus.rd_en  = 1'b1;
    bus.rd_idx = 4'd1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    chk("post-reset no ack",  {127'b0, bus.rd_ack},    128'd0);
    chk("post-reset invalid", {127'b0, bus.key_valid}, 128'd0);
    run_exp(FIPS_KEY, 1'b0, 1'b0, '0);
    rd(4'd10, 1'b0, rk[10], "after reset idx10");
    rd(4'd4,  1'b0, rk[4],  "after reset idx4");
    idle();
    repeat (3) @(negedge clk);
    chk("scoreboard drained", 128'(sbq.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
